code_frame_tx: RTL and testbench

//  Downstream stage of the 8-to-3 one-hot encoder. Accepts 3-bit encoded codes via

---
 rtl/code_frame_tx.sv | 216 +++++++++++++++++++++
 tb/tb_code_frame_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/code_frame_tx.sv
// -----------------------------------------------------------------------------
// code_frame_tx
//   Buffers 3-bit encoder codes in a small FIFO and serialises each one as a
//   UART-style frame: start(0), code bits LSB first, optional even parity,
//   stop(1). The line idles high. Back-to-back frames have no idle gap.
//
//   Optional feature macro: CODE_FRAME_PARITY_EN
//     defined   -> a PARITY bit (^code) follows the data bits
//     undefined -> the parity state and logic are compiled out
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   code_in     code from the encoder
//   code_valid  code_in valid this cycle
//   code_ready  FIFO not full (from registered state only)
//   tx_out      registered serial line
//   tx_busy     high while the FSM is outside IDLE
//   frame_done  1-cycle pulse in the last cycle of each stop bit
//   fifo_level  number of buffered codes
// -----------------------------------------------------------------------------
module code_frame_tx #(
    parameter int CODE_W       = 3,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CODE_W-1:0]             code_in,
    input  logic                          code_valid,
    output logic                          code_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(CODE_W + 1);

    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(CODE_W - 1);

`ifdef CODE_FRAME_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              nonempty_q;   // non-empty flag delayed one cycle
    logic              push, pop;
    logic [CODE_W-1:0] head;

    assign code_ready = (count != DEPTH_L);
    assign fifo_level = count;
    assign push       = code_valid && code_ready;
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only read after being
    // written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= code_in;
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            nonempty_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;   // wraps modulo FIFO_DEPTH
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;                        // both or neither: unchanged
            endcase
            nonempty_q <= (count != '0);
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t            state;
    logic [CW-1:0]     cyc;
    logic [BW-1:0]     bit_cnt;
    logic [CODE_W-1:0] shift;
    logic [CODE_W-1:0] shift_nx;
    logic              cyc_last;
`ifdef CODE_FRAME_PARITY_EN
    logic              parity_q;
`endif

    assign shift_nx = shift >> 1;
    assign cyc_last = (cyc == CYC_LAST);

    // IDLE waits for the delayed flag so the first start bit appears two
    // edges after the push; STOP pops immediately to keep frames contiguous.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        pop = 1'b0;
        if (state == IDLE)
            pop = nonempty_q && (count != '0);
        else if (state == STOP && cyc_last)
            pop = (count != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef CODE_FRAME_PARITY_EN
            parity_q   <= 1'b0;
`endif
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    cyc <= '0;
                    if (pop) begin
                        shift    <= head;
`ifdef CODE_FRAME_PARITY_EN
                        parity_q <= ^head;
`endif
                        state    <= START;
                        tx_out   <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cyc_last) begin
                        cyc     <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx_out  <= shift[0];
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_last) begin
                        cyc <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef CODE_FRAME_PARITY_EN
                            state  <= PARITY;
                            tx_out <= parity_q;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift_nx;
                            tx_out  <= shift_nx[0];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef CODE_FRAME_PARITY_EN
                PARITY: begin
                    if (cyc_last) begin
                        cyc    <= '0;
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Registered pulse: set one edge early so it is high
                    // during the final stop cycle.
                    if (cyc == CYC_PRE) frame_done <= 1'b1;
                    if (cyc_last) begin
                        cyc <= '0;
                        if (pop) begin
                            shift    <= head;
`ifdef CODE_FRAME_PARITY_EN
                            parity_q <= ^head;
`endif
                            state    <= START;
                            tx_out   <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_out  <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_code_frame_tx
//   Directed bench for code_frame_tx (CODE_W=3, CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   Accepted codes go into a scoreboard queue; a line monitor recognises each
//   start bit, pops the expected code and checks every cycle of the frame.
// -----------------------------------------------------------------------------
module tb_code_frame_tx;

    localparam int CODE_W = 3;
    localparam int CLKS   = 4;
    localparam int DEPTH  = 4;
`ifdef CODE_FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = CODE_W + 2 + PAR;
    localparam int FL    = NBITS * CLKS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CODE_W-1:0] code_in = '0;
    logic              code_valid = 1'b0;
    logic              code_ready, tx_out, tx_busy, frame_done;
    logic [2:0]        fifo_level;

    code_frame_tx #(.CODE_W(CODE_W), .CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .tx_out(tx_out), .tx_busy(tx_busy),
        .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    logic [CODE_W-1:0] exp_q [$];
    bit   in_frame = 1'b0;
    bit   b2b = 1'b0;
    int   k = 0;
    logic [15:0] fbits = '0;
    int   exp_lvl [6] = '{1, 2, 2, 3, 4, 4};
    logic [CODE_W-1:0] codes6 [5] = '{3'd1, 3'd6, 3'd3, 3'd5, 3'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame_bits(input logic [CODE_W-1:0] c);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < CODE_W; i++) r[1+i] = c[i];
        if (PAR != 0) r[CODE_W+1] = ^c;
        r[NBITS-1] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 1);
        chk({tag, "_busy_after"}, tx_busy, 0);
    endtask

    // Line monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            b2b      = 1'b0;
        end else begin
            if (frame_done) pulse_cnt++;
            if (b2b) begin
                chk("b2b_start", tx_out, 0);
                b2b = 1'b0;
            end
            if (!in_frame && tx_out == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    fbits    = frame_bits(exp_q.pop_front());
                    in_frame = 1'b1;
                    k        = 0;
                end
            end
            if (in_frame) begin
                chk("frame_bit", tx_out, fbits[k / CLKS]);
                chk("frame_busy", tx_busy, 1);
                chk("frame_done_pos", frame_done, 32'(k == FL - 1));
                k++;
                if (k == FL) begin
                    in_frame = 1'b0;
                    b2b      = (exp_q.size() != 0);
                end
            end else begin
                chk("idle_done", frame_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // Reset held, then released
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", code_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;
        repeat (5) begin
            tick();
            chk("post_rst_tx", tx_out, 1);
            chk("post_rst_busy", tx_busy, 0);
        end
        chk("post_rst_pulses", pulse_cnt, 0);

        // Single code 101, latency check
        p0 = pulse_cnt;
        code_in = 3'b101; code_valid = 1'b1; exp_q.push_back(3'b101);
        tick();                                // push edge N
        code_valid = 1'b0;
        chk("lat_level_n", fifo_level, 1);
        chk("lat_tx_n", tx_out, 1);
        tick();                                // N+1
        chk("lat_tx_n1", tx_out, 1);
        chk("lat_level_n1", fifo_level, 1);
        tick();                                // N+2
        chk("lat_tx_n2", tx_out, 0);
        chk("lat_busy_n2", tx_busy, 1);
        chk("lat_level_n2", fifo_level, 0);
        wait_idle("f101", 200);
        chk("f101_pulses", pulse_cnt, p0 + 1);

        // Single code 011
        p0 = pulse_cnt;
        code_in = 3'b011; code_valid = 1'b1; exp_q.push_back(3'b011);
        tick();
        code_valid = 1'b0;
        wait_idle("f011", 200);
        chk("f011_pulses", pulse_cnt, p0 + 1);

        // Six codes back-to-back with valid held; fifth push fills, sixth refused
        p0 = pulse_cnt;
        code_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            code_in = 3'(i);
            if (i < 5) exp_q.push_back(3'(i));
            tick();
            chk("b2b_level", fifo_level, exp_lvl[i]);
            chk("b2b_ready", code_ready, 32'(exp_lvl[i] != DEPTH));
        end
        code_valid = 1'b0;
        wait_idle("b2b", 600);
        chk("b2b_pulses", pulse_cnt, p0 + 5);

        // Reset during DATA of 111 with two codes queued
        p0 = pulse_cnt;
        code_valid = 1'b1;
        code_in = 3'b111; exp_q.push_back(3'b111); tick();
        code_in = 3'b010; exp_q.push_back(3'b010); tick();
        code_in = 3'b100; exp_q.push_back(3'b100); tick();
        code_valid = 1'b0;
        chk("abort_level_q", fifo_level, 2);
        repeat (CLKS + 1) tick();
        chk("abort_in_data", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_tx", tx_out, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_ready", code_ready, 1);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (30) begin
            tick();
            chk("abort_idle_tx", tx_out, 1);
        end
        chk("abort_idle_busy", tx_busy, 0);
        chk("abort_idle_level", fifo_level, 0);
        chk("abort_pulses", pulse_cnt, p0);

        // Full FIFO, pop and refused push on the same edge
        p0 = pulse_cnt;
        code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            code_in = codes6[i];
            exp_q.push_back(codes6[i]);
            tick();
        end
        chk("full_level", fifo_level, 4);
        chk("full_ready", code_ready, 0);
        code_in = 3'b111;                      // held while full: must be dropped
        repeat (FL - 3) tick();
        chk("full_pre_ready", code_ready, 0);
        chk("full_pre_level", fifo_level, 4);
        tick();                                // pop edge
        chk("full_pop_level", fifo_level, 3);
        chk("full_pop_ready", code_ready, 1);
        code_valid = 1'b0;
        tick();
        chk("full_after_level", fifo_level, 3);
        wait_idle("full", 800);
        chk("full_pulses", pulse_cnt, p0 + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
